// File: rtl/array_arith_pkg.sv
// Shared definitions for the array arithmetic blocks: operand widths, FSM
// encoding, the error code and the bidirectional-pin direction mask.
package array_arith_pkg;

    localparam int unsigned DIVIDEND_W = 8;
    localparam int unsigned DIVISOR_W  = 4;
    localparam int unsigned REM_W      = DIVISOR_W + 1;
    localparam int unsigned N_STEPS    = DIVIDEND_W;
    localparam int unsigned CNT_W      = $clog2(N_STEPS);

    localparam logic [7:0] ERR_CODE    = 8'hFF;
    localparam logic [7:0] UIO_OE_MASK = 8'b1110_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result byte as presented on uo_out
    typedef struct packed {
        logic [DIVISOR_W-1:0] rem;
        logic [DIVISOR_W-1:0] quot;
    } result_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   rem_in  : partial remainder (always < divisor)
//   bit_in  : next dividend bit shifted in at the LSB
//   divisor : 4-bit divisor
//   rem_out : partial remainder after the trial subtraction / restore
//   q_bit   : quotient bit produced by this step
module div_step
    import array_arith_pkg::*;
(
    input  logic [REM_W-1:0]     rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [REM_W-1:0]     rem_out,
    output logic                 q_bit
);

    localparam int unsigned SH_W = REM_W + 1;

    logic [SH_W-1:0]  shifted;
    logic [REM_W-1:0] diff;

    // Shift, trial-subtract, keep the difference only when it is non-negative
    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= SH_W'(divisor));
        diff    = REM_W'(shifted - SH_W'(divisor));
        rem_out = q_bit ? diff : REM_W'(shifted);
    end

endmodule

// File: rtl/tt_um_array_divider_hhrb98.sv
// TinyTapeout user top: sequential restoring divider, 8-bit / 4-bit.
//   ui_in        : dividend, captured at load
//   uio_in[3:0]  : divisor, captured at load; uio_in[4] start request
//   uo_out       : {remainder, quotient}, or 8'hFF on error
//   uio_out      : [5] busy, [6] done, [7] err, others 0
//   uio_oe       : constant 8'hE0
//   ena          : when low, every register holds
module tt_um_array_divider_hhrb98
    import array_arith_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sync;
    logic                    delayed;
    logic                    start_pulse;
    logic [DIVIDEND_W-1:0]   dvd;
    logic [DIVISOR_W-1:0]    dvs;
    logic [REM_W-1:0]        rem;
    logic [DIVIDEND_W-1:0]   quot;
    logic [CNT_W-1:0]        cnt;
    logic                    busy;
    logic                    done;
    logic                    err;

    logic [REM_W-1:0]        rem_nxt;
    logic                    q_bit;
    logic [DIVIDEND_W-1:0]   quot_nxt;
    result_t                 result;

    // Only the start bit and divisor nibble of uio_in are inputs
    logic unused_bits;
    assign unused_bits = &{1'b0, uio_in[7:5]};

    assign start_pulse = sync[SYNC_STAGES-1] & ~delayed;
    assign uio_out     = {err, done, busy, 5'b0_0000};
    assign uio_oe      = UIO_OE_MASK;

    // Single datapath step, reused once per RUN cycle; dividend MSB feeds it
    div_step u_step (
        .rem_in  (rem),
        .bit_in  (dvd[DIVIDEND_W-1]),
        .divisor (dvs),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    assign quot_nxt    = {quot[DIVIDEND_W-2:0], q_bit};
    assign result.rem  = rem_nxt[DIVISOR_W-1:0];
    assign result.quot = quot_nxt[DIVISOR_W-1:0];

    // Start synchroniser, control FSM and working registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sync    <= '0;
            delayed <= 1'b0;
            dvd     <= '0;
            dvs     <= '0;
            rem     <= '0;
            quot    <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            uo_out  <= '0;
        end else if (ena) begin
            sync    <= {sync[SYNC_STAGES-2:0], uio_in[4]};
            delayed <= sync[SYNC_STAGES-1];

            case (state)
                IDLE, DONE: begin
                    if (start_pulse) begin
                        if (uio_in[DIVISOR_W-1:0] == '0) begin
                            // Divide by zero: report straight away, no RUN cycles
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            err    <= 1'b1;
                            uo_out <= ERR_CODE;
                        end else begin
                            state  <= RUN;
                            dvd    <= ui_in;
                            dvs    <= uio_in[DIVISOR_W-1:0];
                            rem    <= '0;
                            quot   <= '0;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            done   <= 1'b0;
                            err    <= 1'b0;
                            uo_out <= '0;
                        end
                    end
                end

                RUN: begin
                    dvd  <= {dvd[DIVIDEND_W-2:0], 1'b0};
                    rem  <= rem_nxt;
                    quot <= quot_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N_STEPS - 1)) begin
                        // Final step: publish result, quotient must fit 4 bits
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (quot_nxt[DIVIDEND_W-1:DIVISOR_W] != '0) begin
                            err    <= 1'b1;
                            uo_out <= ERR_CODE;
                        end else begin
                            err    <= 1'b0;
                            uo_out <= result;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tt_um_array_divider_hhrb98.md
Name: tt_um_array_divider_hhrb98

Overview:
Sequential restoring divider that undoes the team's 4x4 array multiplier.
- Divides an 8-bit dividend by a 4-bit divisor, one quotient bit per clock, using a start/busy/done handshake on the bidirectional pins.
- Returns a 4-bit quotient and a 4-bit remainder, so any product from the 4x4 multiplier can be fed back to recover its factor.
- Sits as a TinyTapeout user top with the standard pin set.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on the start pin (minimum 2).
- N_STEPS, 8, number of restoring iterations; equals the dividend width and is fixed by the pinout.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  design enable; when low, all registers hold.
- ui_in  input  8  dividend; captured at load.
- uio_in  input  8  [3:0] divisor, captured at load; [4] start request; [7:5] unused.
- uio_out  output  8  [4:0] = 0; [5] busy; [6] done; [7] err.
- uio_oe  output  8  constant 8'b1110_0000.
- uo_out  output  8  result: {remainder[3:0], quotient[3:0]}; 8'hFF when err=1.

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - FSM = IDLE; uo_out = 0; busy = 0; done = 0; err = 0.
  - Sync flops = 0; working registers = 0.
- Start detection:
  - uio_in[4] passes through SYNC_STAGES flops plus one delay flop.
  - start_pulse = sync_out & ~delayed.
  - Holding start high yields exactly one pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE + start_pulse, divisor != 0: latch dividend and divisor; clear remainder accumulator and step counter; busy = 1; go to RUN.
  - IDLE + start_pulse, divisor == 0: go directly to DONE with err = 1, uo_out = 8'hFF, done = 1. No RUN cycles.
  - RUN, each clock, one restoring step on a 5-bit partial remainder:
    - shift in the next dividend MSB;
    - trial-subtract the divisor;
    - if the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
    - Counter runs 0..7. After step 8 go to DONE.
  - RUN -> DONE update (registered):
    - busy = 0; done = 1.
    - If the 8-bit quotient > 15: err = 1 and uo_out = 8'hFF.
    - Otherwise: err = 0 and uo_out = {rem[3:0], quot[3:0]}. The remainder is always < divisor <= 15.
  - DONE: outputs hold until the next start_pulse. A new pulse clears done and err and performs the IDLE load actions.
- Latency (SYNC_STAGES = 2): take the first clk edge that samples uio_in[4] high as edge 1.
  - Load occurs at edge 3.
  - busy = 1 from edge 3 through edge 10.
  - done = 1 and result valid after edge 11.
- Boundary rules:
  - A start_pulse during RUN is ignored; the operation is not restarted.
  - Changes to ui_in or uio_in[3:0] after load have no effect.
  - Asserting rst_n low mid-RUN aborts at once and all outputs take their reset values. No partial result is ever visible.
  - ena = 0 freezes the FSM, counter, sync chain and outputs. Resuming continues from the same step.
  - busy and done are never both 1.

Decomposition:
- Shared package/include `array_arith_pkg`:
  - FSM state encodings: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Operand widths: DIVIDEND_W = 8, DIVISOR_W = 4.
  - ERR_CODE = 8'hFF; UIO_OE_MASK.
- One sub-module, `div_step`: combinational single restoring step.
  - Inputs: 5-bit partial remainder, incoming bit, 4-bit divisor.
  - Outputs: next partial remainder, quotient bit.
  - Top instantiates it once and iterates it in time.

Test Plan:
- Reset: rst_n low then high -> uo_out = 0, uio_out = 0, uio_oe = 8'hE0.
- Multiplier round-trip: ui_in = 143, divisor = 11, start pulse -> after edge 11 done = 1, err = 0, uo_out = 8'h0D (q = 13, r = 0); busy high exactly edges 3–10.
- Remainder and boundary cases:
  - ui_in = 200, divisor = 13 -> uo_out = 8'h5F (q = 15, r = 5).
  - ui_in = 225, divisor = 15 -> uo_out = 8'h0F.
- Errors:
  - ui_in = 100, divisor = 0 -> done at edge 3 with no busy, err = 1, uo_out = 8'hFF.
  - ui_in = 240, divisor = 15 -> q = 16 overflow, err = 1, uo_out = 8'hFF after edge 11.
- Handshake robustness:
  - start held high for 30 cycles -> exactly one operation.
  - Second start pulse at edge 6 -> ignored.
  - Operand change during RUN -> result unchanged.
  - New start in DONE -> done drops and the next result is correct.
- Abort and freeze:
  - rst_n asserted at edge 7 -> outputs 0 immediately, FSM IDLE.
  - ena low for 5 cycles mid-RUN -> done delayed by exactly 5 cycles, result unchanged.
